ysyx_23060061_ifu: RTL and testbench
====================================

Name: ysyx_23060061_ifu

Overview:
- Instruction fetch unit of the multi-cycle NPC core; sits directly upstream of the decoder/IDU.
- Holds the PC and issues one word read per instruction to instruction memory over a valid/ready request plus a valid-only response.
- Registers the returned instruction and presents it to the IDU with a valid/ready handshake.
- Waits for the writeback-stage commit, then advances the PC to pc+4 or to a redirect target (jal/jalr/branch).

Parameters:
- ADDR_W, 32, PC and memory address width.
- INST_W, 32, instruction width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  fetch address, equal to pc.
- imem_rsp_valid  in  1  read data valid, one-cycle pulse.
- imem_rsp_data  in  INST_W  read data.
- inst_valid  out  1  instruction valid to IDU.
- inst_ready  in  1  IDU accepts instruction.
- inst  out  INST_W  registered instruction; opcode/funct3 are taken from it.
- pc  out  ADDR_W  PC of the current instruction.
- commit  in  1  current instruction retired.
- commit_redirect  in  1  with commit, next PC is commit_target.
- commit_target  in  ADDR_W  jump/branch target.
- fetch_fault  out  1  misaligned-target fault (see Optional Feature).

Behaviour:
- Clock/reset: one clock, clk; synchronous active-high reset, rst.
- Reset values (rst sampled high): state=S_REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), inst_valid=0, fetch_fault=0. imem_req_valid=0 during the reset cycle.
- FSM states: S_REQ, S_WAIT, S_VALID, S_EXEC, S_FAULT (fault only with the macro).
- S_REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - imem_req_ready=1 -> S_WAIT.
  - imem_rsp_valid is ignored in this state.
- S_WAIT:
  - imem_req_valid=0.
  - imem_rsp_valid=1 -> inst<=imem_rsp_data, then S_VALID.
- S_VALID:
  - inst_valid=1; inst and pc are held stable.
  - inst_ready=1 -> S_EXEC.
- S_EXEC:
  - Waits for commit.
  - commit=1 -> pc<=commit_redirect ? commit_target : pc+4, then S_REQ.
- Latency: request accepted in cycle N -> earliest response N+1 -> inst_valid in cycle N+2. Minimum loop is 4 cycles per instruction, excluding IDU/EXU time.
- Only one request is outstanding; no new request issues before commit.
- pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
- Combinational outputs:
  - imem_req_valid and inst_valid are decoded from state.
  - imem_req_valid is never asserted while inst_valid=1.
- Inputs outside their owning state are ignored: commit outside S_EXEC, inst_ready outside S_VALID, rsp outside S_WAIT.
- Mid-operation reset from any state returns to S_REQ with pc=RESET_PC. Imem shares rst, so no stale response survives reset.
- commit_redirect without commit has no effect.

Optional Feature:
- Macro: YSYX_23060061_IFU_ALIGN_CHECK_EN.
- With the macro:
  - On commit with commit_redirect=1 and commit_target[1:0]!=0: go to S_FAULT and load pc<=commit_target.
  - In S_FAULT: fetch_fault=1, no requests, inst_valid=0. Only rst exits the state.
- Without the macro:
  - The next PC on redirect is {commit_target[ADDR_W-1:2],2'b00}.
  - fetch_fault is tied to 0; S_FAULT does not exist.

Decomposition:
- Shared header global.vh holds:
  - IFU state encodings (3 bits).
  - RESET_PC default.
  - NOP encoding 32'h0000_0013.
- One natural sub-module: ysyx_23060061_ifu_pc, containing the PC register with synchronous reset and the next-PC mux (pc+4 / target / alignment masking).
- The FSM and instruction register stay in the top module.

Test Plan:
- Reset release, imem_req_ready=1, response "addi" 32'h00100093 one cycle later:
  - imem_req_addr=0x80000000.
  - inst_valid rises 2 cycles after request acceptance with inst=32'h00100093.
- inst_ready held low 5 cycles, then high:
  - inst and pc stay stable throughout.
  - Exactly one request per instruction.
- commit without redirect -> next imem_req_addr=0x80000004.
- commit with redirect and target 0x80000100 -> next imem_req_addr=0x80000100.
- imem_req_ready low 3 cycles:
  - imem_req_valid and imem_req_addr held constant.
  - Stray imem_rsp_valid in S_REQ is ignored.
- rst asserted in S_WAIT, then response pulse after release -> pulse ignored, fetch restarts at 0x80000000.
- pc=0xFFFFFFFC with commit, no redirect -> next address 0x00000000.
- Macro on, redirect to 0x80000102 -> fetch_fault=1 and no further requests until rst.
- Macro off, same redirect -> next address 0x80000100.

Source files
------------

// File: rtl/ysyx_23060061_ifu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_23060061_ifu_pkg
// Shared definitions for the instruction fetch unit:
//   - default address/instruction widths and reset PC
//   - NOP encoding loaded into the instruction register on reset
//   - 3-bit FSM state encodings
//   - helper to detect a word-misaligned target
// Optional feature macro: YSYX_23060061_IFU_ALIGN_CHECK_EN
//   (adds the S_FAULT state for misaligned redirect targets).
// ----------------------------------------------------------------------------
package ysyx_23060061_ifu_pkg;

    localparam int          IFU_ADDR_W   = 32;
    localparam int          IFU_INST_W   = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_VALID = 3'd2,
        S_EXEC  = 3'd3
`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
        ,
        S_FAULT = 3'd4
`endif
    } ifu_state_e;

    // A fetch target is legal only on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/ysyx_23060061_ifu_pc.sv
// ----------------------------------------------------------------------------
// ysyx_23060061_ifu_pc
// PC register plus next-PC selection.
//   clk      : core clock
//   rst      : synchronous active-high reset, loads RESET_PC
//   advance  : current instruction committed, update the PC this cycle
//   redirect : with advance, take target instead of pc+4
//   target   : jump/branch target
//   pc       : current PC
// Macro YSYX_23060061_IFU_ALIGN_CHECK_EN: the target is loaded unmodified
// (the FSM traps on a misaligned one). Without it, the low two bits of the
// target are cleared so the PC always stays word aligned.
// ----------------------------------------------------------------------------
module ysyx_23060061_ifu_pc
    import ysyx_23060061_ifu_pkg::*;
#(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] target_sel;

`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
    assign target_sel = target;
`else
    logic unused_align_bits;
    assign unused_align_bits = ^target[1:0];
    assign target_sel = {target[ADDR_W-1:2], 2'b00};
`endif

    always_comb begin
        pc_next = pc_reg;
        if (advance) begin
            // pc+4 wraps naturally modulo 2^ADDR_W
            pc_next = redirect ? target_sel : pc_reg + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/ysyx_23060061_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_23060061_ifu
// Multi-cycle instruction fetch unit. One request per instruction:
//   S_REQ -> S_WAIT -> S_VALID -> S_EXEC -> S_REQ
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   imem_req_valid/ready/addr: fetch request (addr == pc)
//   imem_rsp_valid/data      : valid-only read response
//   inst_valid/ready, inst   : registered instruction to the IDU
//   pc                       : PC of the current instruction
//   commit, commit_redirect, commit_target : writeback retirement info
//   fetch_fault              : misaligned redirect trap
// Macro YSYX_23060061_IFU_ALIGN_CHECK_EN enables the S_FAULT trap state;
// without it fetch_fault is constant 0 and targets are word-aligned.
// ----------------------------------------------------------------------------
module ysyx_23060061_ifu
    import ysyx_23060061_ifu_pkg::*;
#(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter int                INST_W   = IFU_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    input  logic              commit,
    input  logic              commit_redirect,
    input  logic [ADDR_W-1:0] commit_target,
    output logic              fetch_fault
);

    ifu_state_e        state_reg;
    ifu_state_e        state_next;
    logic [INST_W-1:0] inst_reg;
    logic              pc_advance;

    // Only a commit seen in S_EXEC moves the PC; stray commits are ignored.
    assign pc_advance = (state_reg == S_EXEC) && commit;

    ysyx_23060061_ifu_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .advance  (pc_advance),
        .redirect (commit_redirect),
        .target   (commit_target),
        .pc       (pc)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_REQ:   if (imem_req_ready) state_next = S_WAIT;
            S_WAIT:  if (imem_rsp_valid) state_next = S_VALID;
            S_VALID: if (inst_ready)     state_next = S_EXEC;
            S_EXEC: begin
                if (commit) begin
`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
                    if (commit_redirect && is_misaligned(commit_target[1:0])) begin
                        state_next = S_FAULT;
                    end else begin
                        state_next = S_REQ;
                    end
`else
                    state_next = S_REQ;
`endif
                end
            end
`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
            S_FAULT: state_next = S_FAULT;   // sticky until reset
`endif
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_REQ;
            inst_reg  <= INST_W'(IFU_NOP);
        end else begin
            state_reg <= state_next;
            if (state_reg == S_WAIT && imem_rsp_valid) begin
                inst_reg <= imem_rsp_data;
            end
        end
    end

    // Outputs are state decodes; masked during reset so nothing leaks out
    // of whatever state the FSM held when reset arrived.
    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        fetch_fault    = 1'b0;
        if (!rst) begin
            imem_req_valid = (state_reg == S_REQ);
            inst_valid     = (state_reg == S_VALID);
`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
            fetch_fault    = (state_reg == S_FAULT);
`endif
        end
    end

    assign imem_req_addr = pc;
    assign inst          = inst_reg;

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060061_ifu
// Directed bench for the fetch unit. Expected fetch addresses and
// instructions are queued when stimulus is driven and popped when the DUT
// presents a request or an instruction.
// ----------------------------------------------------------------------------
module tb_ysyx_23060061_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        commit;
    logic        commit_redirect;
    logic [31:0] commit_target;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;
    int req_count = 0;
    int exp_reqs  = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];

    always #5 clk = ~clk;

    ysyx_23060061_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .commit          (commit),
        .commit_redirect (commit_redirect),
        .commit_target   (commit_target),
        .fetch_fault     (fetch_fault)
    );

    // Count accepted requests to confirm one request per instruction.
    always @(posedge clk) begin
        if (imem_req_valid && imem_req_ready) req_count <= req_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One full fetch: optional req_ready stall (with a stray response),
    // response one cycle after acceptance, optional IDU stall.
    task automatic fetch(input logic [31:0] data, input int ready_hold, input int idu_hold);
        logic [31:0] exp_a;
        int n;
        n = 0;
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        check("req_valid_seen", 32'(imem_req_valid), 32'd1);
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
        check("req_addr", imem_req_addr, exp_a);
        $display("fetch request addr=%h expected=%h", imem_req_addr, exp_a);
        for (int i = 0; i < ready_hold; i++) begin
            imem_rsp_valid = (i == 1);
            imem_rsp_data  = 32'hDEAD_BEEF;
            step();
            imem_rsp_valid = 1'b0;
            check("req_valid_held", 32'(imem_req_valid), 32'd1);
            check("req_addr_held", imem_req_addr, exp_a);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        exp_reqs++;
        check("wait_no_req", 32'(imem_req_valid), 32'd0);
        check("wait_no_inst_valid", 32'(inst_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        exp_inst_q.push_back(data);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        check("inst_valid_rise", 32'(inst_valid), 32'd1);
        check("inst", inst, exp_inst_q.pop_front());
        check("no_req_while_valid", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < idu_hold; i++) begin
            step();
            check("stall_inst_valid", 32'(inst_valid), 32'd1);
            check("stall_inst", inst, data);
            check("stall_pc", pc, exp_a);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("exec_inst_valid_low", 32'(inst_valid), 32'd0);
        check("exec_no_req", 32'(imem_req_valid), 32'd0);
        // redirect without commit must be ignored
        commit_redirect = 1'b1;
        commit_target   = 32'h1234_0000;
        step();
        commit_redirect = 1'b0;
        commit_target   = '0;
        check("exec_hold_no_req", 32'(imem_req_valid), 32'd0);
        check("exec_pc", pc, exp_a);
        $display("fetch done pc=%h inst=%h", pc, inst);
    endtask

    task automatic do_commit(input logic redirect, input logic [31:0] target, input logic [31:0] next);
        commit          = 1'b1;
        commit_redirect = redirect;
        commit_target   = target;
        exp_addr_q.push_back(next);
        step();
        commit          = 1'b0;
        commit_redirect = 1'b0;
        commit_target   = '0;
        $display("commit redirect=%0b target=%h expect next=%h", redirect, target, next);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] snap;
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        inst_ready = 1'b0;
        commit = 1'b0;
        commit_redirect = 1'b0;
        commit_target = '0;

        step();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        $display("reset state checked");
        step();
        rst = 1'b0;
        exp_addr_q.push_back(32'h8000_0000);

        fetch(32'h0010_0093, 0, 5);
        check("one_req_per_inst_a", 32'(req_count), 32'(exp_reqs));
        do_commit(1'b0, 32'h0, 32'h8000_0004);
        fetch(32'h0020_0113, 3, 0);
        check("one_req_per_inst_b", 32'(req_count), 32'(exp_reqs));
        do_commit(1'b1, 32'h8000_0100, 32'h8000_0100);
        fetch(32'h0030_0193, 0, 1);
        do_commit(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch(32'h0040_0213, 0, 0);
        do_commit(1'b0, 32'h0, 32'h0000_0000);
        fetch(32'h0050_0293, 0, 0);

        // reset while waiting for a response; a later pulse must be ignored
        do_commit(1'b0, 32'h0, 32'h0000_0004);
        check("pre_rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("pre_rst_addr", imem_req_addr, exp_addr_q.pop_front());
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        exp_reqs++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h0BAD_0BAD;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        check("post_rst_inst_valid", 32'(inst_valid), 32'd0);
        check("post_rst_inst_nop", inst, 32'h0000_0013);
        check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        $display("reset in S_WAIT, stale response dropped");
        exp_addr_q.push_back(32'h8000_0000);
        fetch(32'h0060_0313, 0, 0);

`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
        commit = 1'b1;
        commit_redirect = 1'b1;
        commit_target = 32'h8000_0102;
        step();
        commit = 1'b0;
        commit_redirect = 1'b0;
        commit_target = '0;
        check("fault_set", 32'(fetch_fault), 32'd1);
        check("fault_pc", pc, 32'h8000_0102);
        check("fault_inst_valid", 32'(inst_valid), 32'd0);
        snap = 32'(req_count);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("fault_no_req", 32'(imem_req_valid), 32'd0);
            check("fault_sticky", 32'(fetch_fault), 32'd1);
        end
        imem_req_ready = 1'b0;
        check("fault_req_count", 32'(req_count), snap);
        $display("misaligned redirect trapped pc=%h", pc);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("fault_cleared", 32'(fetch_fault), 32'd0);
        exp_addr_q.push_back(32'h8000_0000);
        fetch(32'h0070_0393, 0, 0);
`else
        snap = 32'h8000_0100;
        do_commit(1'b1, 32'h8000_0102, snap);
        check("no_fault", 32'(fetch_fault), 32'd0);
        fetch(32'h0070_0393, 0, 0);
`endif
        check("req_count_final", 32'(req_count), 32'(exp_reqs));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
